pwm_output_stage: RTL and testbench
===================================

// Module: pwm_output_stage
// PURPOSE
//  Consumer end of the channel sample stream: takes the 9-bit compare/amplitude values that the
//  tone channels emit and turns them into a single-bit PWM pin for the board's audio/LED output.
//  Double-buffered: samples are accepted into a shadow register by valid/ready handshake and take
//  effect only on a period boundary, so a change never glitches a period already in progress.
//  Includes a start/stop FSM, underrun detection and a period strobe for upstream pacing.
// PARAMETERS
//  WIDTH   9    sample/compare width in bits
//  TOP     511  last counter value; PWM period = TOP+1 clocks; must satisfy TOP < 2**WIDTH
// PORTS
//  i_clk           in   1      system clock
//  i_reset         in   1      synchronous, active-high reset
//  i_enable        in   1      level; 1 = run, 0 = stop at end of current period
//  i_sample        in   WIDTH  compare value (duty = sample/(TOP+1), clamped to 100%)
//  i_sample_valid  in   1      i_sample is valid this cycle
//  o_sample_ready  out  1      shadow register empty; handshake fires when valid & ready
//  o_pwm           out  1      registered PWM output
//  o_period_stb    out  1      one-cycle pulse on the last clock of each running period
//  o_underrun      out  1      one-cycle pulse: boundary reached with shadow empty
//  o_running       out  1      1 while FSM is in RUN or STOPPING
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, active=0, shadow=0, shadow_full=0; o_pwm=0, o_period_stb=0,
//    o_underrun=0, o_running=0, o_sample_ready=1. Reset mid-period aborts at once; no drain.
//  - Handshake: o_sample_ready = ~shadow_full (combinational from reg). On valid&ready, shadow<=i_sample,
//    shadow_full<=1. Valid while not ready is ignored; sample is held by upstream, not dropped here.
//  - FSM: IDLE --i_enable--> RUN; RUN --~i_enable--> STOPPING; STOPPING --boundary--> IDLE;
//    STOPPING --i_enable before boundary--> RUN (no gap). i_enable during the IDLE->RUN cycle: none.
//  - Counter: cnt counts 0..TOP in RUN/STOPPING, wraps TOP->0; held at 0 in IDLE.
//  - Boundary = cnt==TOP in RUN. At boundary: o_period_stb=1 next cycle; if shadow_full then
//    active<=shadow, shadow_full<=0; else active unchanged and o_underrun pulses next cycle.
//  - Start: the IDLE->RUN transition is a load point: shadow_full -> load as above; empty -> active
//    keeps its value, no underrun flagged. cnt=0 on the first RUN cycle.
//  - Boundary in STOPPING: no load, no underrun, no period strobe; shadow kept for next start.
//  - Simultaneous boundary + valid with shadow empty: counts as underrun; sample goes to shadow and
//    loads at the next boundary (no bypass). With shadow full at boundary, ready=0 that cycle.
//  - Output: o_pwm <= (state!=IDLE) && (active > cnt); one clock lag from cnt. active > TOP -> pin
//    high all period (clamp); active==0 -> low all period. o_pwm=0 from first IDLE cycle.
//  - Widths: cnt is WIDTH bits; compare is unsigned WIDTH-bit; no arithmetic overflow paths.
// STRUCTURE
//  - Shared include pwm_defs.vh: FSM state localparams (IDLE=2'd0, RUN=2'd1, STOPPING=2'd2),
//    default WIDTH/TOP.
//  - Sub-module pwm_period_counter (cnt, wrap, o_at_top, hold-when-disabled); FSM, shadow/active
//    registers and output compare stay in pwm_output_stage.
// TESTING (bench with WIDTH=9, TOP=7)
//  - Reset, push 3, enable -> o_pwm pattern 1,1,1,0,0,0,0,0 per 8 clocks; o_period_stb every 8th.
//  - Push 9 (>TOP) then 0 -> one period all-high, then all-low; no glitch mid-period.
//  - Run with no new sample after first load -> o_underrun pulses each boundary, duty unchanged (3/8).
//  - Push during a period, then valid held with shadow full -> ready=0 until boundary; exactly one
//    accept per period; accepted value appears in the following period.
//  - Drop i_enable at cnt=2 -> period completes, o_running falls after cnt=7, o_pwm=0 thereafter;
//    re-enable at cnt=5 of STOPPING -> stays RUN with no idle gap.
//  - Assert i_reset at cnt=4 with shadow full -> next cycle all outputs at reset values, ready=1.

Source files
------------

// File: rtl/pwm_output_stage_pkg.sv
// -----------------------------------------------------------------------------
// pwm_output_stage_pkg
//   Shared definitions for the PWM output stage: default sample width and
//   period length, the run/stop FSM state encoding, and a small helper that
//   tells whether a state counts as "running" (counter live, pin driven).
// -----------------------------------------------------------------------------
package pwm_output_stage_pkg;

  // Default sample width and last counter value (period = TOP + 1 clocks).
  localparam int unsigned PWM_DEF_WIDTH = 9;
  localparam int unsigned PWM_DEF_TOP   = 511;

  // Run/stop FSM states. STOPPING finishes the current period before idling.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } pwm_state_e;

  // RUN and STOPPING both keep the period counter and the pin live.
  function automatic logic state_is_running(input pwm_state_e state);
    return state != ST_IDLE;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
//   Free-running period counter for the PWM stage. Counts 0..TOP while i_run is
//   high and wraps TOP -> 0; held at 0 while i_run is low.
//
// Ports
//   i_clk     in   1      system clock
//   i_reset   in   1      synchronous, active-high reset (clears count to 0)
//   i_run     in   1      1 = count, 0 = hold at 0
//   o_cnt     out  WIDTH  current count
//   o_at_top  out  1      o_cnt == TOP (last clock of the period)
// -----------------------------------------------------------------------------
module pwm_period_counter
  import pwm_output_stage_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_DEF_WIDTH,
  parameter int unsigned TOP   = PWM_DEF_TOP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_at_top
);

  localparam logic [WIDTH-1:0] TOP_V  = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == TOP_V);

  // The increment never overflows: it only happens while cnt_q < TOP.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_run) begin
      cnt_d = ZERO_V;
    end else if (at_top) begin
      cnt_d = ZERO_V;
    end else begin
      cnt_d = cnt_q + ONE_V;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= ZERO_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt    = cnt_q;
  assign o_at_top = at_top;

endmodule

// File: rtl/pwm_output_stage.sv
// -----------------------------------------------------------------------------
// pwm_output_stage
//   Consumer end of the channel sample stream. Samples arrive by valid/ready
//   into a shadow register and are copied to the active compare register only
//   on a period boundary (or when starting from idle), so a new duty never
//   disturbs a period already in progress. A start/stop FSM lets the output
//   finish its current period before going quiet; underrun and period strobes
//   let the upstream producer pace itself.
//
// Ports
//   i_clk           in   1      system clock
//   i_reset         in   1      synchronous, active-high reset
//   i_enable        in   1      level: 1 = run, 0 = stop at end of period
//   i_sample        in   WIDTH  compare value (duty = sample/(TOP+1), clamped)
//   i_sample_valid  in   1      i_sample is valid this cycle
//   o_sample_ready  out  1      shadow register empty; accept on valid&ready
//   o_pwm           out  1      registered PWM pin
//   o_period_stb    out  1      pulse after the last clock of a running period
//   o_underrun      out  1      pulse: boundary reached with shadow empty
//   o_running       out  1      FSM in RUN or STOPPING
// -----------------------------------------------------------------------------
module pwm_output_stage
  import pwm_output_stage_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_DEF_WIDTH,
  parameter int unsigned TOP   = PWM_DEF_TOP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_pwm,
  output logic             o_period_stb,
  output logic             o_underrun,
  output logic             o_running
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pwm_state_e       state_q,       state_d;
  logic [WIDTH-1:0] active_q,      active_d;
  logic [WIDTH-1:0] shadow_q,      shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             pwm_q,         pwm_d;
  logic             period_stb_q,  period_stb_d;
  logic             underrun_q,    underrun_d;

  logic [WIDTH-1:0] cnt;
  logic             cnt_at_top;
  logic             running;
  logic             accept;
  logic             boundary;
  logic             start;
  logic             load;

  assign running = state_is_running(state_q);

  // ---------------------------------------------------------------------------
  // Period counter: live in RUN/STOPPING, parked at 0 in IDLE so the first RUN
  // cycle always starts a fresh period at cnt = 0.
  // ---------------------------------------------------------------------------
  pwm_period_counter #(
    .WIDTH (WIDTH),
    .TOP   (TOP)
  ) u_counter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_run    (running),
    .o_cnt    (cnt),
    .o_at_top (cnt_at_top)
  );

  // ---------------------------------------------------------------------------
  // Handshake and load points
  // ---------------------------------------------------------------------------
  // Ready reflects only the registered shadow flag, so a sample accepted on a
  // boundary cycle with an empty shadow waits for the next boundary (no
  // bypass into the active register).
  assign accept   = i_sample_valid && !shadow_full_q;

  // Only a boundary in RUN is a load/strobe/underrun point; a STOPPING
  // boundary just ends the run and keeps the shadow for the next start.
  assign boundary = (state_q == ST_RUN) && cnt_at_top;
  assign start    = (state_q == ST_IDLE) && i_enable;
  assign load     = (boundary || start) && shadow_full_q;

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    period_stb_d  = 1'b0;
    underrun_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        // Re-enabling before the boundary resumes without an idle gap; this
        // also wins over a coincident boundary.
        if (i_enable) begin
          state_d = ST_RUN;
        end else if (cnt_at_top) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end

    // accept implies the shadow was empty, so it never collides with load.
    if (accept) begin
      shadow_d      = i_sample;
      shadow_full_d = 1'b1;
    end

    if (boundary) begin
      period_stb_d = 1'b1;
      underrun_d   = !shadow_full_q;
    end
  end

  // Compare is unsigned; active > TOP keeps the pin high for the whole period.
  assign pwm_d = running && (active_q > cnt);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      pwm_q         <= 1'b0;
      period_stb_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      pwm_q         <= pwm_d;
      period_stb_q  <= period_stb_d;
      underrun_q    <= underrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_sample_ready = !shadow_full_q;
  assign o_pwm          = pwm_q;
  assign o_period_stb   = period_stb_q;
  assign o_underrun     = underrun_q;
  assign o_running      = running;

endmodule

// File: tb/tb_pwm_output_stage.sv
// -----------------------------------------------------------------------------
// tb_pwm_output_stage
//   Self-checking bench for pwm_output_stage with WIDTH=9, TOP=7. A reference
//   model tracks "on / stopping", the position inside the period, the duty of
//   the current period and a one-deep queue of pending samples; it predicts
//   the five outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_pwm_output_stage;

  localparam int W   = 9;
  localparam int TOP = 7;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_enable;
  logic [W-1:0] i_sample;
  logic         i_sample_valid;
  logic         o_sample_ready;
  logic         o_pwm;
  logic         o_period_stb;
  logic         o_underrun;
  logic         o_running;

  always #5 clk = ~clk;

  pwm_output_stage #(
    .WIDTH (W),
    .TOP   (TOP)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .o_pwm          (o_pwm),
    .o_period_stb   (o_period_stb),
    .o_underrun     (o_underrun),
    .o_running      (o_running)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_acc   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit         m_on;
  bit         m_stop;
  int         m_phase;
  int         m_duty;
  int         m_pending[$];
  logic [4:0] e_vec;     // {pwm, period_stb, underrun, running, ready}
  int         feed[$];   // samples the upstream wants to deliver, in order

  function automatic logic [4:0] obs_vec();
    return {o_pwm, o_period_stb, o_underrun, o_running, o_sample_ready};
  endfunction

  task automatic model_reset();
    m_on    = 1'b0;
    m_stop  = 1'b0;
    m_phase = 0;
    m_duty  = 0;
    m_pending.delete();
    e_vec   = 5'b00001;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input bit en, input bit v, input int s);
    bit at_end, rdy, pwm, stb, und;
    at_end = m_on && (m_phase == TOP);
    rdy    = (m_pending.size() == 0);
    pwm    = m_on && (m_duty > m_phase);
    stb    = at_end && !m_stop;
    und    = stb && rdy;
    // A new duty takes effect at the end of a running period or on start.
    if ((stb || (!m_on && en)) && !rdy) m_duty = m_pending.pop_front();
    if (v && rdy) m_pending.push_back(s);
    if (!m_on) begin
      if (en) m_on = 1'b1;
      m_stop  = 1'b0;
      m_phase = 0;
    end else begin
      if (m_stop && en) m_stop = 1'b0;
      else if (m_stop && at_end) begin
        m_on   = 1'b0;
        m_stop = 1'b0;
      end else if (!m_stop && !en) m_stop = 1'b1;
      m_phase = at_end ? 0 : m_phase + 1;
    end
    e_vec = {pwm, stb, und, m_on, (m_pending.size() == 0)};
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive + model; checks live in the test tasks)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    i_reset        = 1'b1;
    i_enable       = 1'b0;
    i_sample_valid = 1'b0;
    i_sample       = '0;
    @(posedge clk); #1;
    cyc++;
    model_reset();
  endtask

  task automatic step(input bit en, input bit v, input int s);
    i_reset        = 1'b0;
    i_enable       = en;
    i_sample_valid = v;
    i_sample       = s[W-1:0];
    model_step(en, v, s);
    @(posedge clk); #1;
    cyc++;
  endtask

  // Upstream holds valid with the head of feed until it is accepted.
  task automatic feed_step(input bit en);
    bit v, acc;
    int s;
    v   = (feed.size() > 0);
    s   = v ? feed[0] : 0;
    acc = v && (m_pending.size() == 0);
    step(en, v, s);
    if (acc) begin
      void'(feed.pop_front());
      n_acc++;
      $display("cycle %0d: accepted sample %0d", cyc, s);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    do_reset();
    n_total++;
    if (obs_vec() !== 5'b00001)
      $display("FAIL reset: {pwm,stb,und,run,rdy}=%05b required 00001", obs_vec());
    else n_pass++;
  endtask

  task automatic test_basic_duty();
    int ones, stbs;
    ones = 0; stbs = 0;
    step(1'b0, 1'b1, 3);
    n_total++;
    if (obs_vec() !== e_vec) $display("FAIL basic_push: got %05b required %05b", obs_vec(), e_vec);
    else n_pass++;
    step(1'b1, 1'b0, 0);
    n_total++;
    if (obs_vec() !== e_vec) $display("FAIL basic_start: got %05b required %05b", obs_vec(), e_vec);
    else n_pass++;
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 1'b0, 0);
      ones += int'(o_pwm);
      stbs += int'(o_period_stb);
      n_total++;
      if (obs_vec() !== e_vec)
        $display("FAIL basic_duty cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    n_total++;
    if (ones !== 9) $display("FAIL basic_high_count: got %0d required 9", ones);
    else n_pass++;
    n_total++;
    if (stbs !== 3) $display("FAIL basic_stb_count: got %0d required 3", stbs);
    else n_pass++;
  endtask

  task automatic test_underrun();
    int unds, ones;
    unds = 0; ones = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 0);
      unds += int'(o_underrun);
      ones += int'(o_pwm);
      n_total++;
      if (obs_vec() !== e_vec)
        $display("FAIL underrun cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    n_total++;
    if (unds !== 2) $display("FAIL underrun_count: got %0d required 2", unds);
    else n_pass++;
    n_total++;
    if (ones !== 6) $display("FAIL underrun_duty: got %0d high required 6", ones);
    else n_pass++;
  endtask

  task automatic test_clamp();
    int hi_a, hi_b;
    hi_a = 0; hi_b = 0;
    feed.delete();
    feed.push_back(9);
    feed.push_back(0);
    for (int k = 1; k <= 40; k++) begin
      feed_step(1'b1);
      if (k >= 9 && k <= 16) hi_a += int'(o_pwm);
      if (k >= 17 && k <= 24) hi_b += int'(o_pwm);
      n_total++;
      if (obs_vec() !== e_vec)
        $display("FAIL clamp cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    n_total++;
    if (hi_a !== 8) $display("FAIL clamp_full_period: got %0d high required 8", hi_a);
    else n_pass++;
    n_total++;
    if (hi_b !== 0) $display("FAIL clamp_zero_period: got %0d high required 0", hi_b);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    feed.delete();
    n_acc = 0;
    for (int k = 0; k < 6; k++) feed.push_back(int'($urandom_range(0, TOP + 2)));
    for (int k = 0; k < 56; k++) begin
      feed_step(1'b1);
      n_total++;
      if (obs_vec() !== e_vec)
        $display("FAIL back_to_back cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    n_total++;
    if (n_acc !== 6) $display("FAIL back_to_back_accepts: got %0d required 6", n_acc);
    else n_pass++;
  endtask

  task automatic test_stop_restart();
    int guard, fall_steps, gaps;
    guard = 0;
    while (m_phase != 2 && guard < 16) begin
      step(1'b1, 1'b0, 0);
      guard++;
      n_total++;
      if (obs_vec() !== e_vec) $display("FAIL stop_align: got %05b required %05b", obs_vec(), e_vec);
      else n_pass++;
    end
    // Drop enable at cnt=2 and let the period finish.
    fall_steps = 0;
    guard = 0;
    do begin
      step(1'b0, 1'b0, 0);
      fall_steps++;
      guard++;
      n_total++;
      if (obs_vec() !== e_vec) $display("FAIL stop_drain cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end while (o_running && guard < 16);
    n_total++;
    if (fall_steps !== 6) $display("FAIL stop_fall_time: got %0d cycles required 6", fall_steps);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 0);
      n_total++;
      if (obs_vec() !== e_vec) $display("FAIL stop_idle cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    // Restart, then stop again and re-enable at cnt=5 while STOPPING.
    guard = 0;
    do begin
      step(1'b1, 1'b0, 0);
      guard++;
      n_total++;
      if (obs_vec() !== e_vec) $display("FAIL restart cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end while (m_phase != 2 && guard < 16);
    guard = 0;
    while (m_phase != 5 && guard < 16) begin
      step(1'b0, 1'b0, 0);
      guard++;
      n_total++;
      if (obs_vec() !== e_vec) $display("FAIL stopping cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    gaps = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 0);
      gaps += int'(!o_running);
      n_total++;
      if (obs_vec() !== e_vec) $display("FAIL reenable cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
    n_total++;
    if (gaps !== 0) $display("FAIL reenable_gap: got %0d idle cycles required 0", gaps);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (m_phase != 1 && guard < 16) begin
      step(1'b1, 1'b0, 0);
      guard++;
    end
    step(1'b1, 1'b1, int'($urandom_range(1, TOP)));
    guard = 0;
    while (m_phase != 4 && guard < 16) begin
      step(1'b1, 1'b0, 0);
      guard++;
    end
    n_total++;
    if (o_sample_ready !== 1'b0 || o_running !== 1'b1)
      $display("FAIL reset_mid_setup: ready=%b run=%b required ready=0 run=1", o_sample_ready, o_running);
    else n_pass++;
    do_reset();
    n_total++;
    if (obs_vec() !== 5'b00001)
      $display("FAIL reset_mid: got %05b required 00001", obs_vec());
    else n_pass++;
    step(1'b0, 1'b0, 0);
    n_total++;
    if (obs_vec() !== e_vec) $display("FAIL reset_mid_after: got %05b required %05b", obs_vec(), e_vec);
    else n_pass++;
  endtask

  task automatic test_random();
    bit en;
    en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 99) < 6) en = !en;
        step(en, 1'($urandom_range(0, 1)), int'($urandom_range(0, TOP + 3)));
      end
      n_total++;
      if (obs_vec() !== e_vec)
        $display("FAIL random cycle %0d: got %05b required %05b", cyc, obs_vec(), e_vec);
      else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_reset        = 1'b1;
    i_enable       = 1'b0;
    i_sample_valid = 1'b0;
    i_sample       = '0;
    model_reset();
    test_reset();
    test_basic_duty();
    test_underrun();
    test_clamp();
    test_back_to_back();
    test_stop_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
